// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues sequential word fetches (one in flight), buffers returned
// words with their PCs in a small FIFO and supports redirect-with-flush.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [31:0]                   mem_req_addr,
    input  logic                          mem_rsp_valid,
    input  logic [31:0]                   mem_rsp_data,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [31:0]                   inst_data,
    output logic [31:0]                   inst_pc,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic [31:0]   r_fifo_data [FIFO_DEPTH];
    logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_can_issue;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    // Issue only with a free slot, so the FIFO can never overflow.
    assign w_can_issue   = (r_state == S_FETCH) && (r_count < DEPTH_C) && !redirect_valid && !resetn;
    assign w_accept      = w_can_issue && mem_req_ready;
    assign mem_req_valid = w_can_issue;
    assign mem_req_addr  = r_fetch_pc;

    assign inst_valid = (r_count != '0) && !resetn;
    assign inst_data  = inst_valid ? r_fifo_data[r_rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;
    assign fifo_count = resetn ? '0 : r_count;
    assign w_pop      = inst_valid && inst_ready && !redirect_valid;
    assign w_unused   = &{1'b0, redirect_pc[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_accept) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    w_push      = !redirect_valid;
                    w_state_nxt = S_FETCH;
                end else if (redirect_valid) begin
                    w_state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (mem_rsp_valid) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Buffer storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_req_pc <= r_fetch_pc;
        end
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mem_rsp_data;
            r_fifo_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run,
// checked each cycle against a transaction-level queue model of the fetch stream.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fifo_count(fifo_count)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: expected buffered PCs, next fetch address, request bookkeeping.
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch = RST_PC;
    bit          awaiting = 1'b0;
    bit          live = 1'b0;

    // Memory model: single pending response, data = addr ^ KEY.
    bit          mem_pend = 1'b0;
    int          mem_delay = 0;
    logic [31:0] mem_addr = 32'h0;
    int          min_delay = 0;
    int          max_delay = 0;

    bit          s_acc, s_rv, s_iv;
    logic [31:0] s_addr;
    int          s_cnt;
    int          cyc = 0;
    logic [31:0] accq[$];
    logic [31:0] popq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit rdr, input logic [31:0] rpc, input bit rdy, input bit ir);
        bit exp_req;
        @(negedge clk);
        resetn         = rst;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        inst_ready     = ir;
        mem_req_ready  = rdy && !mem_pend;
        mem_rsp_valid  = mem_pend && (mem_delay == 0);
        mem_rsp_data   = mem_rsp_valid ? (mem_addr ^ KEY) : $urandom;
        #1;
        cyc++;
        s_acc  = mem_req_valid && mem_req_ready;
        s_rv   = mem_req_valid;
        s_addr = mem_req_addr;
        s_iv   = inst_valid;
        s_cnt  = int'(fifo_count);
        if (rst) begin
            check("rst_req_valid", 32'(mem_req_valid), 32'd0);
            check("rst_inst_valid", 32'(inst_valid), 32'd0);
            check("rst_fifo_count", 32'(fifo_count), 32'd0);
        end else begin
            exp_req = !awaiting && (exp_q.size() < 4) && !rdr;
            check("req_valid", 32'(mem_req_valid), 32'(exp_req));
            if (exp_req) check("req_addr", mem_req_addr, exp_fetch);
            check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
            if (exp_q.size() > 0) begin
                check("inst_valid", 32'(inst_valid), 32'd1);
                check("inst_pc", inst_pc, exp_q[0]);
                check("inst_data", inst_data, exp_q[0] ^ KEY);
            end else begin
                check("inst_valid_empty", 32'(inst_valid), 32'd0);
                check("inst_pc_empty", inst_pc, 32'h0);
                check("inst_data_empty", inst_data, 32'h0);
            end
        end
        if (rst) begin
            exp_q.delete();
            exp_fetch = RST_PC;
            awaiting  = 1'b0;
            live      = 1'b0;
        end else if (rdr) begin
            exp_q.delete();
            exp_fetch = {rpc[31:2], 2'b00};
            live      = 1'b0;
            if (mem_rsp_valid && awaiting) awaiting = 1'b0;
        end else begin
            if (ir && exp_q.size() > 0) popq.push_back(exp_q.pop_front());
            if (mem_rsp_valid && awaiting) begin
                awaiting = 1'b0;
                if (live) exp_q.push_back(mem_addr);
                live = 1'b0;
            end
            if (s_acc) begin
                awaiting  = 1'b1;
                live      = 1'b1;
                exp_fetch = exp_fetch + 32'd4;
                accq.push_back(s_addr);
            end
        end
        if (mem_rsp_valid) mem_pend = 1'b0;
        else if (mem_pend) mem_delay--;
        if (s_acc) begin
            mem_pend  = 1'b1;
            mem_addr  = s_addr;
            mem_delay = int'($urandom_range(max_delay, min_delay));
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wait_acc(input bit ir);
        int n = 0;
        do begin
            step(1'b0, 1'b0, 32'h0, 1'b1, ir);
            n++;
        end while (!s_acc && n < 50);
        check("acc_timeout", 32'(s_acc), 32'd1);
    endtask

    task automatic check_pops(input string tag, input logic [31:0] first, input int n);
        check({tag, "_len"}, 32'(popq.size() >= n), 32'd1);
        if (popq.size() >= n)
            for (int i = 0; i < n; i++) check(tag, popq[i], first + 32'(4 * i));
    endtask

    initial begin
        int a;
        int n;

        // Ideal memory, decode always ready: stream 0,4,8,12 and first-inst latency.
        do_reset();
        popq.delete();
        wait_acc(1'b1);
        a = cyc;
        n = 0;
        do begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            n++;
        end while (!s_iv && n < 20);
        check("first_inst_latency", 32'(cyc - a), 32'd2);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_pops("seq_pc", 32'h0, 4);

        // Decode stalled: FIFO fills to 4, requests stop, then drains in order.
        do_reset();
        accq.delete();
        repeat (20) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("full_count", 32'(s_cnt), 32'd4);
        check("full_req_valid", 32'(s_rv), 32'd0);
        check("full_accepts", 32'(accq.size()), 32'd4);
        popq.delete();
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_pops("drain_pc", 32'h0, 4);

        // Redirect while waiting on a slow response.
        do_reset();
        min_delay = 3; max_delay = 3;
        wait_acc(1'b1);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1);
        popq.delete();
        min_delay = 0; max_delay = 0;
        wait_acc(1'b1);
        check("redir_wait_addr", s_addr, 32'h0000_0100);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_pops("redir_wait_pc", 32'h0000_0100, 2);

        // Redirect coinciding with the response.
        do_reset();
        wait_acc(1'b1);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
        popq.delete();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("redir_rsp_req_valid", 32'(s_rv), 32'd1);
        check("redir_rsp_addr", s_addr, 32'h0000_0200);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_pops("redir_rsp_pc", 32'h0000_0200, 2);

        // Address wrap past the top of memory.
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        accq.delete();
        popq.delete();
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("wrap_len", 32'(accq.size() >= 3), 32'd1);
        if (accq.size() >= 3) begin
            check("wrap_req0", accq[0], 32'hFFFF_FFF8);
            check("wrap_req1", accq[1], 32'hFFFF_FFFC);
            check("wrap_req2", accq[2], 32'h0000_0000);
        end
        check_pops("wrap_pc", 32'hFFFF_FFF8, 3);

        // Reset pulse in WAIT with two entries buffered; late response must be ignored.
        do_reset();
        min_delay = 2; max_delay = 2;
        n = 0;
        do begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            n++;
        end while (!(s_acc && s_cnt == 2) && n < 80);
        check("wait2_timeout", 32'(s_acc && s_cnt == 2), 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        popq.delete();
        min_delay = 0; max_delay = 0;
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("post_rst_count", 32'(s_cnt), 32'd0);
        check("post_rst_valid", 32'(s_iv), 32'd0);
        wait_acc(1'b1);
        check("post_rst_addr", s_addr, RST_PC);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_pops("post_rst_pc", RST_PC, 2);

        // Randomized traffic: stalls, variable memory latency, redirects, resets.
        min_delay = 0; max_delay = 3;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(1, 0) == 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)));
            step($urandom_range(99, 0) == 0, $urandom_range(24, 0) == 0, rpc,
                 $urandom_range(3, 0) != 0, $urandom_range(4, 0) < 3);
        end
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the single-cycle core's decode/control path.
- Generates sequential word addresses and issues them to instruction memory over a valid/ready request channel with one outstanding request.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) input that flushes all buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  reset. Synchronous, active-high: asserted when 1, despite the name.
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  32  word-aligned fetch address.
- mem_rsp_valid  input  1  response valid; always accepted, no backpressure.
- mem_rsp_data  input  32  returned instruction word.
- inst_valid  output  1  head FIFO entry valid.
- inst_ready  input  1  decode consumes head entry.
- inst_data  output  32  head instruction.
- inst_pc  output  32  PC of head instruction.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (resetn=1 at a clk edge):
  - fetch_pc <= RESET_PC, FIFO emptied, state <= FETCH.
  - mem_req_valid, inst_valid and fifo_count are 0 while reset is asserted.
  - inst_data and inst_pc read 0 when the FIFO is empty.
  - Reset mid-transaction drops any outstanding response.
  - The memory must tolerate a response arriving after reset; it is ignored because state is FETCH.
- States:
  - FETCH: mem_req_valid = (fifo_count < FIFO_DEPTH) && !redirect_valid. mem_req_addr = fetch_pc. On mem_req_valid && mem_req_ready: fetch_pc += 4 (mod 2^32; 0xFFFFFFFC wraps to 0), req_pc <= fetch_pc, go WAIT.
  - WAIT: mem_req_valid = 0. On mem_rsp_valid: push {req_pc, mem_rsp_data}, go FETCH.
  - DISCARD: mem_req_valid = 0. On mem_rsp_valid: drop the data, go FETCH.
- Credit rule: a request is issued only when a FIFO slot is free at issue time. Only one request is ever in flight, and the FIFO never overflows.
- Output: inst_valid = (fifo_count != 0). Pop on inst_valid && inst_ready. Push and pop in the same cycle leave the count unchanged.
- Redirect: redirect_valid=1 at an edge has priority over push, pop and issue.
  - FIFO cleared, fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - From FETCH with the request accepted that cycle: go DISCARD. mem_req_valid is held 0 that cycle, so no accept can occur.
  - From FETCH with no request accepted: stay FETCH.
  - From WAIT with no mem_rsp_valid: go DISCARD.
  - From WAIT with mem_rsp_valid in the same cycle: response dropped, go FETCH.
  - From DISCARD: stay DISCARD unless mem_rsp_valid is high that cycle, then go FETCH.
  - No instruction fetched before the redirect may ever appear on inst_*.
- Request stability: once mem_req_valid=1, mem_req_addr is stable until accepted. The only exceptions are redirect and reset, which may withdraw the request.
- Latency: with a zero-wait memory (ready=1, response one cycle after accept):
  - First inst_valid appears 2 cycles after the first accept.
  - Steady-state throughput is 1 instruction per 2 cycles.
  - Redirect to first redirected inst_valid takes at least 3 cycles.
- Backpressure: with inst_ready=0, fetching continues until fifo_count == FIFO_DEPTH, then mem_req_valid drops. It reasserts in the cycle after the first pop.

Test Plan:
- Reset release, RESET_PC=0, ideal memory returning addr^32'hA5A5A5A5, inst_ready=1 -> inst_pc sequence 0,4,8,12 with matching data; first inst_valid 2 cycles after first accept.
- inst_ready=0 for 20 cycles -> fifo_count reaches 4, mem_req_valid=0 after the 4th accept, no push lost; releasing ready drains PCs 0,4,8,12 in order.
- Redirect to 32'h00000103 while in WAIT -> outstanding response discarded, FIFO flushed, next mem_req_addr=0x100, next inst_pc=0x100.
- Redirect asserted in the same cycle as mem_rsp_valid in WAIT -> data not enqueued; next request is to redirect_pc, issued the following cycle.
- redirect_pc=32'hFFFFFFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
- resetn pulsed high for 1 cycle while in WAIT with 2 entries buffered -> inst_valid=0 and fifo_count=0 after the edge; late response ignored; fetch restarts at RESET_PC.
